imm_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of the immediate decode path. It accepts an opcode, register fields, funct3, a 32-bit immediate and an immediate format, then range-checks the immediate and packs it into the I/S/B/U/J bit layout. It sits in the debug/instruction-injection path and in the self-checking stimulus generator. Its output fed back through the decoder must reproduce the original immediate.

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_pack_check.sv | 58 +++++
 rtl/imm_encoder.sv | 128 ++++++++++++
 tb/tb_imm_encoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants and helpers for RV32I immediate encoding.
package imm_pkg;

  // Immediate format selectors, shared with the control unit and decoder
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_BAD_FMT  = 2'b11
  } imm_err_e;

  // ADDI x0,x0,0 substituted for any rejected request
  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when v[31:msb] are all equal, i.e. v is representable as a
  // signed field whose sign bit sits at position msb.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] sh;
    sh = $signed(v) >>> msb;
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/imm_pack_check.sv
// Combinational immediate range/alignment check and RV32I field packing.
module imm_pack_check
  import imm_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic [31:0] instr,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [31:0] packed_word;
  imm_err_e    code;

  // Pack per format and classify; misalignment is tested ahead of range
  always_comb begin
    packed_word = '0;
    code        = ERR_NONE;
    case (imm_src)
      IMM_I: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits_signed(imm, 11)) code = ERR_RANGE;
      end
      IMM_S: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits_signed(imm, 11)) code = ERR_RANGE;
      end
      IMM_B: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])                      code = ERR_MISALIGN;
        else if (!fits_signed(imm, 12))  code = ERR_RANGE;
      end
      IMM_U: begin
        packed_word = {imm[31:12], rd, opcode};
        if (imm[11:0] != '0) code = ERR_RANGE;
      end
      IMM_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                      code = ERR_MISALIGN;
        else if (!fits_signed(imm, 20))  code = ERR_RANGE;
      end
      default: code = ERR_BAD_FMT;
    endcase
  end

  // Rejected requests are replaced by a NOP
  always_comb begin
    err      = (code != ERR_NONE);
    err_code = code;
    instr    = err ? NOP : packed_word;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage streaming RV32I instruction encoder with saturating beat counters.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_src,
  input  logic [31:0]      in_imm,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] encoded_count,
  output logic [CNT_W-1:0] error_count
);

  logic        s1_valid;
  logic [2:0]  s1_src;
  logic [31:0] s1_imm;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic        s1_ready;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic [1:0]  s2_code;

  logic [31:0] pk_instr;
  logic        pk_err;
  logic [1:0]  pk_code;
  logic        beat;

  // Handshake: each stage advances when the one ahead is empty or draining
  always_comb begin
    s1_ready  = !s2_valid || out_ready;
    in_ready  = (!s1_valid || s1_ready) && !rst;
    beat      = s2_valid && out_ready;
    out_valid = s2_valid;
  end

  // Stage 1: raw request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src <= in_imm_src;
        s1_imm <= in_imm;
        s1_op  <= in_opcode;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f3  <= in_funct3;
      end
    end
  end

  imm_pack_check u_pack (
    .imm_src  (s1_src),
    .imm      (s1_imm),
    .opcode   (s1_op),
    .rd       (s1_rd),
    .rs1      (s1_rs1),
    .rs2      (s1_rs2),
    .funct3   (s1_f3),
    .instr    (pk_instr),
    .err      (pk_err),
    .err_code (pk_code)
  );

  // Stage 2: packed result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
      s2_code  <= '0;
    end else if (s1_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= pk_instr;
        s2_err   <= pk_err;
        s2_code  <= pk_code;
      end
    end
  end

  always_comb begin
    out_instr    = s2_instr;
    out_err      = s2_err;
    out_err_code = s2_code;
  end

  // Saturating delivery counters; clear wins over a coincident beat
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      encoded_count <= '0;
      error_count   <= '0;
    end else if (beat) begin
      if (encoded_count != '1)         encoded_count <= encoded_count + 1'b1;
      if (s2_err && error_count != '1) error_count   <= error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and round-trip bench for imm_encoder.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_imm_src;
  logic [31:0]   in_imm;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [1:0]    out_err_code;
  logic          cnt_clr;
  logic [CW-1:0] encoded_count;
  logic [CW-1:0] error_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_imm_src    (in_imm_src),
    .in_imm        (in_imm),
    .in_opcode     (in_opcode),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_funct3     (in_funct3),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_err       (out_err),
    .out_err_code  (out_err_code),
    .cnt_clr       (cnt_clr),
    .encoded_count (encoded_count),
    .error_count   (error_count)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [31:0] instr, input logic err,
                              input logic [1:0] code);
    vec_t v;
    v.src = src; v.imm = imm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.instr = instr; v.err = err; v.code = code;
    return v;
  endfunction

  // Reference immediate decoder
  function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] i);
    case (src)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  task automatic drive(input vec_t v);
    in_imm_src = v.src; in_imm = v.imm; in_opcode = v.op; in_rd = v.rd;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct3 = v.f3;
  endtask

  // Issue one request on an idle pipe and wait for its result
  task automatic run_one(input vec_t v, output logic [31:0] instr, output logic err,
                         output logic [1:0] code, output int lat);
    int n;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("output_timeout", 32'(out_valid), 32'd1);
    instr = out_instr;
    err   = out_err;
    code  = out_err_code;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] r_instr;
    logic        r_err;
    logic [1:0]  r_code;
    int          lat;
    int          idx, got, n;
    logic        rdy;
    logic [31:0] held;
    vec_t        exp_bp[3];
    vec_t        rv;
    logic [31:0] rnd;
    logic        ghost;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_imm_src = '0; in_imm = '0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;

    vecs[0]  = mk(IMM_I, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFF1_0093, 1'b0, 2'b00);
    vecs[1]  = mk(IMM_B, 32'd8,         7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0020_8463, 1'b0, 2'b00);
    vecs[2]  = mk(IMM_B, 32'd7,         7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0013, 1'b1, 2'b10);
    vecs[3]  = mk(IMM_B, 32'd4096,      7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0013, 1'b1, 2'b01);
    vecs[4]  = mk(IMM_U, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 1'b0, 2'b00);
    vecs[5]  = mk(IMM_U, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b01);
    vecs[6]  = mk(3'b101, 32'd7,        7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b11);
    vecs[7]  = mk(IMM_J, 32'd2048,      7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_00EF, 1'b0, 2'b00);
    vecs[8]  = mk(IMM_S, 32'hFFFF_FFFC, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 32'hFE31_2E23, 1'b0, 2'b00);
    vecs[9]  = mk(IMM_I, 32'd2048,      7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b01);
    vecs[10] = mk(IMM_J, 32'd3,         7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b10);
    vecs[11] = mk(IMM_J, 32'h0010_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b01);
    vecs[12] = mk(IMM_I, 32'hFFFF_F800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0013, 1'b0, 2'b00);
    vecs[13] = mk(3'b111, 32'd0,        7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1, 2'b11);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_code", 32'(out_err_code), 32'd0);
    chk("rst_encoded_count", 32'(encoded_count), 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int unsigned i = 0; i < 14; i++) begin
      run_one(vecs[i], r_instr, r_err, r_code, lat);
      chk($sformatf("vec%0d_instr", i), r_instr, vecs[i].instr);
      chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_code", i), 32'(r_code), 32'(vecs[i].code));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: three requests against a stalled consumer
    exp_bp[0] = vecs[0]; exp_bp[1] = vecs[4]; exp_bp[2] = vecs[7];
    @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (idx < 3) begin drive(exp_bp[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      rdy = in_ready;
      @(posedge clk);
      if (rdy && in_valid) idx++;
      @(negedge clk);
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = out_instr;
    chk("bp_head_instr", held, exp_bp[0].instr);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
    got = 0;
    for (int unsigned c = 0; c < 12; c++) begin
      if (out_valid) begin
        if (got < 3) chk($sformatf("bp_order%0d", got), out_instr, exp_bp[got].instr);
        got++;
      end
      if (idx < 3) begin drive(exp_bp[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      rdy = in_ready;
      @(posedge clk);
      if (rdy && in_valid) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_total_accepts", 32'(idx), 32'd3);
    chk("bp_total_outputs", 32'(got), 32'd3);

    // Counters: clear, then 5 beats with 2 errors on a 2-bit counter
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_encoded", 32'(encoded_count), 32'd0);
    chk("clr_error", 32'(error_count), 32'd0);
    run_one(vecs[0], r_instr, r_err, r_code, lat);
    run_one(vecs[2], r_instr, r_err, r_code, lat);
    run_one(vecs[4], r_instr, r_err, r_code, lat);
    run_one(vecs[3], r_instr, r_err, r_code, lat);
    run_one(vecs[1], r_instr, r_err, r_code, lat);
    @(posedge clk);
    #1;
    chk("sat_encoded", 32'(encoded_count), 32'd3);
    chk("sat_error", 32'(error_count), 32'd2);

    // Clear coincident with an error beat
    run_one(vecs[2], r_instr, r_err, r_code, lat);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_beat_encoded", 32'(encoded_count), 32'd0);
    chk("clr_beat_error", 32'(error_count), 32'd0);
    chk("clr_beat_consumed", 32'(out_valid), 32'd0);

    // Reset with two requests in flight
    run_one(vecs[0], r_instr, r_err, r_code, lat);
    @(posedge clk);
    #1 chk("pre_rst_encoded", 32'(encoded_count), 32'd1);
    out_ready = 1'b0;
    @(negedge clk);
    drive(vecs[0]); in_valid = 1'b1;
    @(posedge clk);
    #1 drive(vecs[4]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    chk("midrst_encoded", 32'(encoded_count), 32'd0);
    chk("midrst_error", 32'(error_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    ghost = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("midrst_discarded", 32'(ghost), 32'd0);

    // Random legal requests must decode back to the original immediate
    for (int unsigned k = 0; k < 1000; k++) begin
      rnd = $urandom;
      rv.src = 3'($urandom_range(0, 4));
      case (rv.src)
        IMM_I, IMM_S: rv.imm = {{20{rnd[11]}}, rnd[11:0]};
        IMM_B:        rv.imm = {{19{rnd[12]}}, rnd[12:1], 1'b0};
        IMM_U:        rv.imm = {rnd[31:12], 12'b0};
        default:      rv.imm = {{11{rnd[20]}}, rnd[20:1], 1'b0};
      endcase
      rv.op = 7'($urandom); rv.rd = 5'($urandom); rv.rs1 = 5'($urandom);
      rv.rs2 = 5'($urandom); rv.f3 = 3'($urandom);
      rv.instr = '0; rv.err = 1'b0; rv.code = '0;
      run_one(rv, r_instr, r_err, r_code, lat);
      chk($sformatf("rt%0d_imm", k), decode(rv.src, r_instr), rv.imm);
      chk($sformatf("rt%0d_err", k), 32'(r_err), 32'd0);
      chk($sformatf("rt%0d_op", k), 32'(r_instr[6:0]), 32'(rv.op));
    end

    n = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
